// File: rtl/data_mem_responder.sv
// 256x16 single-ported data memory responder: level-held reads, pulsed writes,
// and a one-entry write buffer that keeps writes ahead of any waiting read.
module data_mem_responder #(
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        readReq,
    input  logic        writeReq,
    input  logic [7:0]  memAddrLoadStore,
    input  logic [15:0] memValueStore,
    output logic [15:0] memValueLoad,
    output logic        valueReady,
    output logic        writeDone,
    output logic        busy,
    output logic        wrOverflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2,
        WR_WAIT = 2'd3
    } stateType;

    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    stateType    state;
    stateType    stateNext;
    logic [3:0]  latCnt;
    logic [3:0]  latCntNext;
    logic        bufValid;
    logic        bufValidNext;
    logic [7:0]  bufAddr;
    logic [15:0] bufData;
    logic [7:0]  opAddr;
    logic [15:0] opData;

    logic        acceptBuf;
    logic        acceptWr;
    logic        acceptRd;
    logic        readFire;
    logic        commitEn;
    logic        wrPending;
    logic        bufLoad;
    logic        bufDrop;

    // Array is never touched by reset; contents start at zero.
    logic [15:0] mem [256] = '{default: 16'h0000};

    // Next-state and per-edge decisions. The buffered write always wins in
    // IDLE so a waiting read observes every earlier write.
    always_comb begin
        stateNext  = state;
        latCntNext = latCnt;
        acceptBuf  = 1'b0;
        acceptWr   = 1'b0;
        acceptRd   = 1'b0;
        readFire   = 1'b0;
        commitEn   = 1'b0;
        case (state)
            IDLE: begin
                if (bufValid) begin
                    acceptBuf  = 1'b1;
                    stateNext  = WR_WAIT;
                    latCntNext = WR_LOAD;
                end else if (writeReq) begin
                    acceptWr   = 1'b1;
                    stateNext  = WR_WAIT;
                    latCntNext = WR_LOAD;
                end else if (readReq) begin
                    acceptRd   = 1'b1;
                    stateNext  = RD_WAIT;
                    latCntNext = RD_LOAD;
                end
            end
            RD_WAIT: begin
                if (latCnt == 4'd0) begin
                    readFire  = 1'b1;
                    stateNext = RD_DONE;
                end else begin
                    latCntNext = latCnt - 4'd1;
                end
            end
            RD_DONE: begin
                if (!readReq) begin
                    stateNext = IDLE;
                end
            end
            WR_WAIT: begin
                if (latCnt == 4'd0) begin
                    commitEn  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    latCntNext = latCnt - 4'd1;
                end
            end
            default: stateNext = IDLE;
        endcase

        // A write not taken directly this edge goes to the buffer if the
        // buffer is empty or is being drained on this same edge.
        wrPending    = writeReq && !acceptWr;
        bufLoad      = wrPending && (!bufValid || acceptBuf);
        bufDrop      = wrPending && bufValid && !acceptBuf;
        bufValidNext = bufLoad || (bufValid && !acceptBuf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            latCnt       <= 4'd0;
            bufValid     <= 1'b0;
            memValueLoad <= 16'h0000;
            valueReady   <= 1'b0;
            writeDone    <= 1'b0;
            wrOverflow   <= 1'b0;
        end else begin
            state      <= stateNext;
            latCnt     <= latCntNext;
            bufValid   <= bufValidNext;
            valueReady <= readFire;
            writeDone  <= commitEn;
            if (readFire) begin
                memValueLoad <= mem[opAddr];
            end
            if (bufDrop) begin
                wrOverflow <= 1'b1;
            end
        end
    end

    // Address/data holding registers carry no reset; their valid flags do.
    always_ff @(posedge clk) begin
        if (acceptBuf) begin
            opAddr <= bufAddr;
            opData <= bufData;
        end else if (acceptWr) begin
            opAddr <= memAddrLoadStore;
            opData <= memValueStore;
        end else if (acceptRd) begin
            opAddr <= memAddrLoadStore;
        end
        if (bufLoad) begin
            bufAddr <= memAddrLoadStore;
            bufData <= memValueStore;
        end
    end

    always_ff @(posedge clk) begin
        if (commitEn) begin
            mem[opAddr] <= opData;
        end
    end

    assign busy = (state != IDLE) || bufValid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic
// checked against an array model of memory contents.
module tb_data_mem_responder;

    localparam int RL   = 2;
    localparam int WL   = 1;
    localparam int WL_B = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        readReq = 1'b0, writeReq = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        valueReady, writeDone, busy, wrOverflow;

    logic        readReqB = 1'b0, writeReqB = 1'b0;
    logic [7:0]  addrB = 8'h00;
    logic [15:0] wdataB = 16'h0000;
    logic [15:0] rdataB;
    logic        valueReadyB, writeDoneB, busyB, wrOverflowB;

    int checks = 0;
    int errors = 0;
    int doneCntA = 0;
    int doneCntB = 0;
    logic [15:0] model [256];

    always #5 clk = ~clk;

    data_mem_responder dutA (
        .clk(clk), .rst(rst), .readReq(readReq), .writeReq(writeReq),
        .memAddrLoadStore(addr), .memValueStore(wdata), .memValueLoad(rdata),
        .valueReady(valueReady), .writeDone(writeDone), .busy(busy),
        .wrOverflow(wrOverflow)
    );

    data_mem_responder #(.READ_LATENCY(RL), .WRITE_LATENCY(WL_B)) dutB (
        .clk(clk), .rst(rst), .readReq(readReqB), .writeReq(writeReqB),
        .memAddrLoadStore(addrB), .memValueStore(wdataB), .memValueLoad(rdataB),
        .valueReady(valueReadyB), .writeDone(writeDoneB), .busy(busyB),
        .wrOverflow(wrOverflowB)
    );

    // valueReady and writeDone must never coincide on either instance.
    always @(negedge clk) begin
        if (writeDone)  doneCntA++;
        if (writeDoneB) doneCntB++;
        if (!rst) begin
            checks++;
            if ((valueReady && writeDone) !== 1'b0 || (valueReadyB && writeDoneB) !== 1'b0) begin
                errors++;
                $display("FAIL pulse_exclusive got A vr=%b wd=%b B vr=%b wd=%b required never both high",
                         valueReady, writeDone, valueReadyB, writeDoneB);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout bench did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic doWriteA(input logic [7:0] a, input logic [15:0] d);
        writeReq = 1'b1;
        addr     = a;
        wdata    = d;
        tick();
        writeReq = 1'b0;
    endtask

    task automatic waitIdleA(output bit timedOut);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        timedOut = busy;
    endtask

    task automatic doReadA(input logic [7:0] a, output logic [15:0] d, output bit timedOut);
        int n = 0;
        readReq = 1'b1;
        addr    = a;
        do begin
            tick();
            n++;
        end while (!valueReady && n < 60);
        timedOut = !valueReady;
        d        = rdata;
        readReq  = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] pickAddr();
        int r = $urandom_range(0, 5);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_load got %h required 0000", rdata); end
        checks++;
        if ({valueReady, writeDone, busy, wrOverflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got vr/wd/busy/ovf=%b required 0000", {valueReady, writeDone, busy, wrOverflow});
        end
        checks++;
        if ({busyB, wrOverflowB, rdataB} !== 18'h0) begin
            errors++;
            $display("FAIL reset_instB got busy=%b ovf=%b load=%h required 0 0 0000", busyB, wrOverflowB, rdataB);
        end
    endtask

    task automatic test_write_read;
        int lat;
        // Write presented on the same negedge that releases reset.
        rst = 1'b0;
        doWriteA(8'h10, 16'hBEEF);
        checks++;
        if (busy !== 1'b1 || writeDone !== 1'b0) begin
            errors++; $display("FAIL wr_accept got busy=%b wd=%b required busy=1 wd=0", busy, writeDone);
        end
        lat = 0;
        do begin tick(); lat++; end while (!writeDone && lat < 20);
        checks++;
        if (lat != WL || writeDone !== 1'b1) begin
            errors++; $display("FAIL wr_latency got %0d edges (wd=%b) required %0d", lat, writeDone, WL);
        end
        model[8'h10] = 16'hBEEF;
        tick();
        checks++;
        if (writeDone !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_pulse_end got wd=%b busy=%b required 0 0", writeDone, busy);
        end
        readReq = 1'b1;
        addr    = 8'h10;
        tick();
        lat = 0;
        do begin tick(); lat++; end while (!valueReady && lat < 20);
        checks++;
        if (lat != RL || valueReady !== 1'b1) begin
            errors++; $display("FAIL rd_latency got %0d edges (vr=%b) required %0d", lat, valueReady, RL);
        end
        checks++;
        if (rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data got %h required beef", rdata); end
    endtask

    task automatic test_held_read;
        int vrCount = 1;
        int busyLow = 0;
        repeat (5) begin
            tick();
            if (valueReady) vrCount++;
            if (busy !== 1'b1) busyLow++;
        end
        checks++;
        if (vrCount != 1) begin errors++; $display("FAIL held_read_pulses got %0d required 1", vrCount); end
        checks++;
        if (busyLow != 0) begin errors++; $display("FAIL held_read_busy got %0d low cycles required 0", busyLow); end
        checks++;
        if (rdata !== 16'hBEEF) begin errors++; $display("FAIL held_read_hold got %h required beef", rdata); end
        readReq = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL held_read_release got busy=%b required 0", busy); end
    endtask

    task automatic test_buffered;
        int wd = 0;
        int n = 0;
        logic [15:0] d;
        bit to;
        doWriteA(8'h20, 16'h1111);
        if (writeDone) wd++;
        doWriteA(8'h21, 16'h2222);
        if (writeDone) wd++;
        readReq = 1'b1;
        addr    = 8'h21;
        while (!valueReady && n < 40) begin
            tick();
            n++;
            if (writeDone) wd++;
        end
        d = rdata;
        checks++;
        if (valueReady !== 1'b1 || wd != 2) begin
            errors++; $display("FAIL buf_order got vr=%b commits_before_read=%0d required vr=1 commits=2", valueReady, wd);
        end
        checks++;
        if (d !== 16'h2222) begin errors++; $display("FAIL buf_read got %h required 2222", d); end
        readReq = 1'b0;
        tick();
        checks++;
        if (wrOverflow !== 1'b0) begin errors++; $display("FAIL buf_overflow got %b required 0", wrOverflow); end
        model[8'h20] = 16'h1111;
        model[8'h21] = 16'h2222;
        doReadA(8'h20, d, to);
        checks++;
        if (to || d !== 16'h1111) begin errors++; $display("FAIL buf_first_commit got %h (timeout=%b) required 1111", d, to); end
    endtask

    task automatic test_same_edge;
        logic [15:0] d = 16'($urandom_range(1, 65535));
        bit sawWd = 1'b0;
        int n = 0;
        writeReq = 1'b1;
        readReq  = 1'b1;
        addr     = 8'h33;
        wdata    = d;
        do begin
            tick();
            n++;
            writeReq = 1'b0;
            if (writeDone) sawWd = 1'b1;
        end while (!valueReady && n < 40);
        checks++;
        if (valueReady !== 1'b1 || !sawWd) begin
            errors++; $display("FAIL same_edge_order got vr=%b write_done_first=%b required 1 1", valueReady, sawWd);
        end
        checks++;
        if (rdata !== d) begin errors++; $display("FAIL same_edge_data got %h required %h", rdata, d); end
        readReq = 1'b0;
        tick();
        model[8'h33] = d;
    endtask

    task automatic test_reset_abort;
        logic [15:0] d;
        bit to;
        int vr = 0;
        int wd = 0;
        doWriteA(8'hFF, 16'h5A5A);
        waitIdleA(to);
        model[8'hFF] = 16'h5A5A;
        doWriteA(8'hFF, 16'hAAAA);
        rst = 1'b1;
        #1;
        checks++;
        if ({rdata, valueReady, writeDone, busy, wrOverflow} !== 20'h0) begin
            errors++;
            $display("FAIL abort_outputs got load=%h vr=%b wd=%b busy=%b ovf=%b required all zero",
                     rdata, valueReady, writeDone, busy, wrOverflow);
        end
        tick();
        if (writeDone) wd++;
        rst = 1'b0;
        tick();
        if (writeDone) wd++;
        checks++;
        if (wd != 0) begin errors++; $display("FAIL abort_write_done got %0d pulses required 0", wd); end
        readReq = 1'b1;
        addr    = 8'h10;
        tick();
        rst     = 1'b1;
        readReq = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            if (valueReady) vr++;
        end
        checks++;
        if (vr != 0) begin errors++; $display("FAIL abort_read_ready got %0d pulses required 0", vr); end
        doReadA(8'hFF, d, to);
        checks++;
        if (to || d !== 16'h5A5A) begin errors++; $display("FAIL abort_keep_ff got %h (timeout=%b) required 5a5a", d, to); end
        doReadA(8'h10, d, to);
        checks++;
        if (to || d !== 16'hBEEF) begin errors++; $display("FAIL reset_keeps_array got %h (timeout=%b) required beef", d, to); end
    endtask

    task automatic test_overflow;
        logic [15:0] dv [3];
        logic [15:0] expv [3];
        int t;
        int n;
        for (int i = 0; i < 3; i++) dv[i] = 16'($urandom_range(1, 65535));
        expv[0] = dv[0];
        expv[1] = dv[1];
        expv[2] = 16'h0000;
        writeReqB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addrB  = 8'(8'h40 + i);
            wdataB = dv[i];
            tick();
        end
        writeReqB = 1'b0;
        checks++;
        if (wrOverflowB !== 1'b1) begin errors++; $display("FAIL ovf_set got %b required 1", wrOverflowB); end
        t = 2;
        while (!writeDoneB && t < 30) begin tick(); t++; end
        checks++;
        if (t != WL_B) begin errors++; $display("FAIL ovf_first_latency got %0d edges required %0d", t, WL_B); end
        n = 0;
        while (busyB && n < 60) begin tick(); n++; end
        for (int i = 0; i < 3; i++) begin
            readReqB = 1'b1;
            addrB    = 8'(8'h40 + i);
            n = 0;
            do begin tick(); n++; end while (!valueReadyB && n < 40);
            checks++;
            if (valueReadyB !== 1'b1 || rdataB !== expv[i]) begin
                errors++; $display("FAIL ovf_contents[%0d] got %h (vr=%b) required %h", i, rdataB, valueReadyB, expv[i]);
            end
            readReqB = 1'b0;
            tick();
        end
        checks++;
        if (doneCntB != 2 || wrOverflowB !== 1'b1) begin
            errors++; $display("FAIL ovf_commits got %0d commits ovf=%b required 2 commits ovf=1", doneCntB, wrOverflowB);
        end
    endtask

    task automatic test_random;
        int base = doneCntA;
        int writes = 0;
        int idleTimeouts = 0;
        logic [7:0]  a1, a2;
        logic [15:0] d1, d2, got;
        bit to;
        for (int i = 0; i < 40; i++) begin
            int op = $urandom_range(0, 3);
            a1 = pickAddr();
            a2 = pickAddr();
            d1 = 16'($urandom);
            d2 = 16'($urandom);
            case (op)
                0: begin
                    doWriteA(a1, d1);
                    model[a1] = d1;
                    writes++;
                    waitIdleA(to);
                    if (to) idleTimeouts++;
                end
                1, 3: begin
                    doWriteA(a1, d1);
                    doWriteA(a2, d2);
                    model[a1] = d1;
                    model[a2] = d2;
                    writes += 2;
                    if (op == 3) begin
                        doReadA(($urandom_range(0, 1) != 0) ? a1 : a2, got, to);
                        checks++;
                        if (to || got !== model[addr]) begin
                            errors++; $display("FAIL rand_queued_read[%0d] @%h got %h (timeout=%b) required %h",
                                               i, addr, got, to, model[addr]);
                        end
                    end
                    waitIdleA(to);
                    if (to) idleTimeouts++;
                end
                default: begin
                    doReadA(a1, got, to);
                    checks++;
                    if (to || got !== model[a1]) begin
                        errors++; $display("FAIL rand_read[%0d] @%h got %h (timeout=%b) required %h", i, a1, got, to, model[a1]);
                    end
                end
            endcase
        end
        tick();
        tick();
        checks++;
        if (idleTimeouts != 0) begin errors++; $display("FAIL rand_idle got %0d timeouts required 0", idleTimeouts); end
        checks++;
        if (doneCntA - base != writes || wrOverflow !== 1'b0) begin
            errors++; $display("FAIL rand_commits got %0d commits ovf=%b required %0d ovf=0", doneCntA - base, wrOverflow, writes);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        test_reset();
        test_write_read();
        test_held_read();
        test_buffered();
        test_same_edge();
        test_reset_abort();
        test_overflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter READ_LATENCY, default 2, clock edges from read accept to valueReady; legal range 1..15.
REQ-002 Parameter WRITE_LATENCY, default 1, clock edges from write accept to array commit and writeDone; legal range 1..15.
REQ-003 Reset rst is asynchronous and active-high; clock clk; all state changes on rising clk edge only.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 readReq  input  1  level read request, held high until valueReady is seen.
REQ-007 writeReq  input  1  write request, one-cycle pulse.
REQ-008 memAddrLoadStore  input  8  word address, shared by read and write.
REQ-009 memValueStore  input  16  write data.
REQ-010 memValueLoad  output  16  read data.
REQ-011 valueReady  output  1  one-cycle read-complete pulse.
REQ-012 writeDone  output  1  one-cycle write-commit pulse.
REQ-013 busy  output  1  high when state is not IDLE or the write buffer is valid.
REQ-014 wrOverflow  output  1  sticky flag: a write was dropped.

Function
REQ-015 Storage SHALL be 256 x 16-bit, single-ported, with contents zero at time zero.
REQ-016 FSM states SHALL be IDLE, RD_WAIT, RD_DONE, WR_WAIT; a 4-bit latency counter SHALL run in RD_WAIT and WR_WAIT.
REQ-017 IDLE accept priority at each edge: (1) buffered write, (2) writeReq, (3) readReq; exactly one operation is accepted per edge.
REQ-018 Write accept at edge N SHALL latch address and data, enter WR_WAIT, commit the array at edge N+WRITE_LATENCY, pulse writeDone high for that cycle, and return to IDLE.
REQ-019 Read accept at edge N SHALL latch the address and enter RD_WAIT.
REQ-020 At edge N+READ_LATENCY, memValueLoad SHALL load the array word at that address and valueReady SHALL pulse high for one cycle; the FSM then enters RD_DONE.
REQ-021 memValueLoad SHALL hold its value until the next read response.
REQ-022 RD_DONE SHALL return to IDLE at the first edge where readReq is sampled low; a held readReq SHALL never cause a second read.
REQ-023 writeReq sampled high when it is not accepted at that edge SHALL be stored in the one-entry write buffer (address and data) if the buffer is empty.
REQ-024 If the buffer is already full, that writeReq SHALL be dropped and wrOverflow set; wrOverflow stays set until rst.
REQ-025 When the buffered write is accepted and writeReq is also high at the same edge, the new write SHALL refill the buffer at that edge.
REQ-026 readReq arriving while busy SHALL wait (level-held); pending buffered writes always precede it, so a read returns the most recently written data for its address.
REQ-027 Address arithmetic SHALL be unsigned 8-bit with no wrap hazards; addresses 0x00 and 0xFF are both valid.
REQ-028 valueReady and writeDone SHALL never be high in the same cycle.

Reset
REQ-029 rst SHALL force state IDLE, counter 0, buffer empty, memValueLoad 0, valueReady 0, writeDone 0, busy 0, wrOverflow 0.
REQ-030 rst SHALL NOT modify array contents.
REQ-031 A write aborted by rst before its commit edge SHALL NOT change the array.
REQ-032 A read aborted by rst SHALL produce no valueReady.
REQ-033 After rst deasserts, requests SHALL be accepted from the first rising edge.

Verification
REQ-034 Default parameters: write 0xBEEF @0x10, accepted at edge N -> writeDone high at N+1; then read 0x10 -> valueReady one cycle exactly 2 edges after accept, memValueLoad=0xBEEF.
REQ-035 readReq held high 5 cycles after valueReady -> exactly one valueReady; busy stays high until readReq is sampled low.
REQ-036 Write @0x20=0x1111 in flight, write @0x21=0x2222 pulsed, then read @0x21 queued -> both commits occur in order before the read; the read returns 0x2222; wrOverflow=0.
REQ-037 WRITE_LATENCY=4, three writeReq pulses on consecutive edges from IDLE -> first accepted, second buffered, third dropped; wrOverflow=1; array holds first and second only.
REQ-038 rst asserted mid-write @0xFF=0xAAAA before the commit edge -> outputs zero, no writeDone; a later read @0xFF returns the prior value.
REQ-039 writeReq and readReq high at the same IDLE edge -> write completes first; read then accepted and returns the written value.
